instruction_queue: RTL and testbench

- Circular FIFO between instruction fetch and the decoder.
- Buffers fetched instruction/PC pairs and presents the head entry to the decoder one per cycle.
- Applies backpressure to fetch when full; honours dispatcher stalls.
- Flushes on a decoder JAL redirect or a ROB misprediction reset.

---
 rtl/instruction_queue_pkg.sv | 18 +
 rtl/instruction_queue.sv | 138 +++++++++++++
 tb/tb_instruction_queue.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_queue_pkg.sv
// Shared sizing constants for the instruction queue between fetch and decode.
// InstQueueSizeLog sits next to the instruction and address widths so that
// fetch, queue and decoder all agree on one set of numbers.
package instruction_queue_pkg;

  // log2 of the number of queue entries
  localparam int InstQueueSizeLog = 4;
  // instruction word width
  localparam int IDWidth          = 32;
  // program counter width
  localparam int AddressWidth     = 32;

  // Entry count for a given pointer width.
  function automatic int depth_of(input int size_log);
    return 1 << size_log;
  endfunction

endpackage

// File: rtl/instruction_queue.sv
// Purpose : circular FIFO of fetched {instruction, PC} pairs feeding the decoder.
// Latency : 1 cycle from push to decoder visibility; 0 cycles into an empty
//           queue when INSTQUEUE_BYPASS_EN is defined.
// Backpr. : instqueue_if_full_out stops fetch; dispatcher stall holds the head.
//
// Ports:
//   clk_in / rst_in / rdy_in         clock, sync active-high reset, global ready
//   if_instqueue_*                   push side from fetch (en, inst, pc)
//   instqueue_if_full_out            queue full, fetch must not push
//   instqueue_decoder_*              head entry to decoder (en, inst, pc)
//   decoder_instqueue_rst_in         JAL redirect flush from decoder
//   dispatcher_instqueue_stall_in    downstream cannot take an instruction
//   rob_instqueue_rst_in             misprediction flush
//
// Optional feature macro: INSTQUEUE_BYPASS_EN (empty-queue zero-latency path).
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int QUEUE_SIZE_LOG = InstQueueSizeLog,
  parameter int IDW            = IDWidth,
  parameter int AW             = AddressWidth
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           if_instqueue_en_in,
  input  logic [IDW-1:0] if_instqueue_inst_in,
  input  logic [AW-1:0]  if_instqueue_pc_in,
  output logic           instqueue_if_full_out,
  output logic           instqueue_decoder_en_out,
  output logic [IDW-1:0] instqueue_decoder_inst_out,
  output logic [AW-1:0]  instqueue_decoder_pc_out,
  input  logic           decoder_instqueue_rst_in,
  input  logic           dispatcher_instqueue_stall_in,
  input  logic           rob_instqueue_rst_in
);

  localparam int DEPTH = depth_of(QUEUE_SIZE_LOG);
  localparam logic [QUEUE_SIZE_LOG:0]   FULL_CNT = (QUEUE_SIZE_LOG+1)'(DEPTH);
  localparam logic [QUEUE_SIZE_LOG-1:0] PTR_ONE  = QUEUE_SIZE_LOG'(1);
  localparam logic [QUEUE_SIZE_LOG:0]   CNT_ONE  = (QUEUE_SIZE_LOG+1)'(1);

  // Pointer and occupancy state. Full vs empty is told apart by r_count only,
  // since head == tail in both cases.
  logic [QUEUE_SIZE_LOG-1:0] r_head;
  logic [QUEUE_SIZE_LOG-1:0] r_tail;
  logic [QUEUE_SIZE_LOG:0]   r_count;

  // Entry storage; never reset, only slots between head and tail are read.
  logic [IDW-1:0] r_inst_mem [DEPTH];
  logic [AW-1:0]  r_pc_mem   [DEPTH];

  logic w_flush;
  logic w_full;
  logic w_empty;
  logic w_can_deq;
  logic w_push;
  logic w_bypass;
  logic w_store;
  logic w_pop;

  assign w_flush = decoder_instqueue_rst_in | rob_instqueue_rst_in;
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // The decoder flush is left out of the dequeue gate: it is derived from the
  // instruction being presented, so including it would close a loop. The JAL
  // that raises it is therefore consumed in the same cycle.
  assign w_can_deq = rdy_in & !rst_in & !rob_instqueue_rst_in &
                     !dispatcher_instqueue_stall_in;

  assign w_push = if_instqueue_en_in & !w_full & !w_flush;

`ifdef INSTQUEUE_BYPASS_EN
  // Empty queue: hand the fetched word straight to the decoder. As with the
  // normal dequeue path the decoder flush is not part of this gate (it would
  // depend on the very word being bypassed); if it fires, the queue is
  // cleared at the edge anyway and nothing was written.
  assign w_bypass = w_can_deq & w_empty & if_instqueue_en_in;
`else
  assign w_bypass = 1'b0;
`endif

  assign instqueue_decoder_en_out = w_can_deq & (!w_empty | w_bypass);
  assign instqueue_if_full_out    = w_full;

  // A bypassed entry is neither stored nor popped from storage.
  assign w_store = w_push & !w_bypass;
  assign w_pop   = instqueue_decoder_en_out & !w_bypass;

  always_comb begin
    instqueue_decoder_inst_out = '0;
    instqueue_decoder_pc_out   = '0;
    if (w_bypass) begin
      instqueue_decoder_inst_out = if_instqueue_inst_in;
      instqueue_decoder_pc_out   = if_instqueue_pc_in;
    end else if (instqueue_decoder_en_out) begin
      instqueue_decoder_inst_out = r_inst_mem[r_head];
      instqueue_decoder_pc_out   = r_pc_mem[r_head];
    end
  end

  // Storage write; w_store already excludes flush and full.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && w_store) begin
      r_inst_mem[r_tail] <= if_instqueue_inst_in;
      r_pc_mem[r_tail]   <= if_instqueue_pc_in;
    end
  end

  // Pointers and count. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_store) begin
          r_tail <= r_tail + PTR_ONE;
        end
        if (w_pop) begin
          r_head <= r_head + PTR_ONE;
        end
        case ({w_store, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue (default build, bypass checked only
// when INSTQUEUE_BYPASS_EN is defined). Inputs change 1 ns after the rising
// edge; outputs are compared on the falling edge.
module tb_instruction_queue;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        if_en;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        full_out;
  logic        dec_en;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_rst;
  logic        stall;
  logic        rob_rst;

  int n_vec = 0;
  int n_err = 0;

  instruction_queue dut (
    .clk_in                        (clk),
    .rst_in                        (rst_in),
    .rdy_in                        (rdy_in),
    .if_instqueue_en_in            (if_en),
    .if_instqueue_inst_in          (if_inst),
    .if_instqueue_pc_in            (if_pc),
    .instqueue_if_full_out         (full_out),
    .instqueue_decoder_en_out      (dec_en),
    .instqueue_decoder_inst_out    (dec_inst),
    .instqueue_decoder_pc_out      (dec_pc),
    .decoder_instqueue_rst_in      (dec_rst),
    .dispatcher_instqueue_stall_in (stall),
    .rob_instqueue_rst_in          (rob_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        push;
    logic [31:0] pc;
    logic        drst;
    logic        stall;
    logic        rob;
    logic        e_en;
    logic [31:0] e_pc;
    logic        e_full;
  } vec_t;

  vec_t tbl [29];

  // Instruction word tagged from its PC so inst/pc pairing is also checked.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic apply(input string name,
                       input logic rst, input logic rdy, input logic push,
                       input logic [31:0] pc, input logic drst,
                       input logic st, input logic rob,
                       input logic e_en, input logic [31:0] e_pc,
                       input logic e_full);
    logic [31:0] e_inst;
    rst_in  = rst;
    rdy_in  = rdy;
    if_en   = push;
    if_pc   = pc;
    if_inst = inst_of(pc);
    dec_rst = drst;
    stall   = st;
    rob_rst = rob;
    e_inst  = e_en ? inst_of(e_pc) : 32'h0;
    @(negedge clk);
    n_vec++;
    if (dec_en !== e_en || dec_pc !== (e_en ? e_pc : 32'h0) ||
        dec_inst !== e_inst || full_out !== e_full) begin
      n_err++;
      $display("FAIL %s: got en=%0b pc=%h inst=%h full=%0b, need en=%0b pc=%h inst=%h full=%0b",
               name, dec_en, dec_pc, dec_inst, full_out,
               e_en, (e_en ? e_pc : 32'h0), e_inst, e_full);
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  int          pushed;
  int          popped;
  logic        w_push;
  logic        w_stall;
  logic        w_en;
  logic [31:0] w_pc;

  initial begin
    // rst, rdy, push, pc, drst, stall, rob | en, pc, full
    // basic flow: 3 pushes, en pulses the cycle after each
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b0, 1'b0, 1'b0, 1'b1, 32'h4,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h8,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    // JAL flush: 5 queued under stall, head consumed, concurrent push dropped
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h28, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h2C, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h30, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h34, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    // ROB flush: en suppressed that cycle, empty afterwards
    tbl[15] = '{1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 32'h48, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 32'h4C, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 32'h50, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    // rdy low for 3 cycles mid-stream: nothing moves, push ignored
    tbl[22] = '{1'b0, 1'b1, 1'b1, 32'h60, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[23] = '{1'b0, 1'b1, 1'b1, 32'h64, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 1'b1, 32'h68, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[25] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[26] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[27] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h64, 1'b0};
    tbl[28] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0};

    rst_in = 1'b1; rdy_in = 1'b1; if_en = 1'b0; if_pc = '0; if_inst = '0;
    dec_rst = 1'b0; stall = 1'b0; rob_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 29; i++) begin
      apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].rdy, tbl[i].push,
            tbl[i].pc, tbl[i].drst, tbl[i].stall, tbl[i].rob,
            tbl[i].e_en, tbl[i].e_pc, tbl[i].e_full);
    end

    // Fill all 16 slots under stall, 17th push ignored, then drain in order.
    apply("full_rst", 1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 16; i++) begin
      apply($sformatf("full_fill%0d", i), 0, 1, 1, 32'h200 + 4 * i, 0, 1, 0,
            0, 32'h0, 0);
    end
    apply("full_17th", 0, 1, 1, 32'h999, 0, 1, 0, 0, 32'h0, 1);
    for (int k = 0; k < 16; k++) begin
      apply($sformatf("full_drain%0d", k), 0, 1, 0, 32'h0, 0, 0, 0,
            1, 32'h200 + 4 * k, (k == 0));
    end
    apply("full_empty", 0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);

    // 40 entries streamed with occupancy kept in 1..3 so both pointers wrap.
    apply("wrap_rst", 1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
    q.delete();
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 200; c++) begin
      if (pushed == 40 && q.size() == 0) break;
      w_push  = (pushed < 40) && !((c % 5 == 2) && q.size() > 1);
      w_stall = (q.size() != 0) && (q.size() < 3) && (c % 3 == 0);
      w_en    = !w_stall && (q.size() != 0);
      w_pc    = w_en ? q[0] : 32'h0;
      apply($sformatf("wrap_c%0d", c), 0, 1, w_push, 32'h1000 + 4 * pushed,
            0, w_stall, 0, w_en, w_pc, 0);
      if (w_en) begin
        void'(q.pop_front());
        popped++;
      end
      if (w_push) begin
        q.push_back(32'h1000 + 4 * pushed);
        pushed++;
      end
    end
    n_vec++;
    if (popped != 40) begin
      n_err++;
      $display("FAIL wrap_count: got %0d pops, need 40", popped);
    end

`ifdef INSTQUEUE_BYPASS_EN
    // Empty queue: pushed word reaches the decoder in the same cycle and is
    // not retained.
    apply("byp_rst", 1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
    apply("byp_push", 0, 1, 1, 32'h100, 0, 0, 0, 1, 32'h100, 0);
    apply("byp_after", 0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
